// File: rtl/qsram_ctrl.sv
// Sequencer for a 16-cell SRAM array: one write, read or refresh pulse at a time.
// Define QSRAM_REFRESH_EN to build the periodic refresh engine; without it RefreshEdge is tied low.
module qsram_ctrl #(
    parameter int REFRESH_PERIOD = 64,
    parameter int PULSE_WIDTH    = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       ReqValid,
    input  logic       ReqWrite,
    input  logic [3:0] ReqAddr,
    input  logic       ReqData,
    output logic       ReqReady,
    output logic       RespValid,
    output logic       RespData,
    output logic [3:0] CellAddr,
    output logic       CellWriteData,
    input  logic       CellReadData,
    output logic       WriteEdge,
    output logic       ReadEdge,
    output logic       RefreshEdge
);

    localparam int PCW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, REFRESH} state_t;

    state_t         state, state_next;
    logic [PCW-1:0] pulse_cnt;
    logic           pulse_last;
    logic           accept;
    logic           refresh_pending;
    logic           refresh_start;
    logic [3:0]     refresh_addr;

    assign pulse_last    = (pulse_cnt == PULSE_LAST);
    assign refresh_start = (state == IDLE) && refresh_pending;
    assign accept        = ReqValid && ReqReady;
    assign WriteEdge     = (state == WRITE);
    assign ReadEdge      = (state == READ);

`ifdef QSRAM_REFRESH_EN
    localparam int RCW = $clog2(REFRESH_PERIOD);
    localparam logic [RCW-1:0] REFRESH_LAST = RCW'(REFRESH_PERIOD - 1);

    logic [RCW-1:0] refresh_cnt;
    logic           refresh_wrap;
    logic           refresh_done;

    assign refresh_wrap = (refresh_cnt == REFRESH_LAST);
    assign refresh_done = (state == REFRESH) && pulse_last;
    assign ReqReady     = (state == IDLE) && !refresh_pending;
    assign RefreshEdge  = (state == REFRESH);

    // A wrap landing while a refresh is already owed does not queue a second one.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            refresh_cnt     <= '0;
            refresh_pending <= 1'b0;
            refresh_addr    <= 4'd0;
        end else begin
            refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + RCW'(1);
            if (refresh_wrap)
                refresh_pending <= 1'b1;
            else if (refresh_done)
                refresh_pending <= 1'b0;
            if (refresh_done)
                refresh_addr <= refresh_addr + 4'd1;
        end
    end
`else
    assign refresh_pending = 1'b0;
    assign refresh_addr    = 4'd0;
    assign ReqReady        = (state == IDLE);
    assign RefreshEdge     = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (refresh_pending)
                    state_next = REFRESH;
                else if (ReqValid)
                    state_next = ReqWrite ? WRITE : READ;
            end
            WRITE, READ, REFRESH: begin
                if (pulse_last)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address and write data are captured once so the cells see them stable across the pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            CellAddr      <= 4'd0;
            CellWriteData <= 1'b0;
            pulse_cnt     <= '0;
            RespValid     <= 1'b0;
            RespData      <= 1'b0;
        end else begin
            RespValid <= 1'b0;
            if (accept) begin
                CellAddr      <= ReqAddr;
                CellWriteData <= ReqData;
            end else if (refresh_start) begin
                CellAddr <= refresh_addr;
            end
            if (state != IDLE)
                pulse_cnt <= pulse_last ? '0 : pulse_cnt + PCW'(1);
            else
                pulse_cnt <= '0;
            if ((state == READ) && pulse_last) begin
                RespValid <= 1'b1;
                RespData  <= CellReadData;
            end
        end
    end

endmodule

// File: tb/tb_qsram_ctrl.sv
// Scoreboard bench for qsram_ctrl: a driver queues expected pulses/responses, a monitor checks them.
// Refresh scenarios run when QSRAM_REFRESH_EN is defined; otherwise the no-refresh idle check runs.
module tb_qsram_ctrl;

    localparam int PW = 2;
    localparam int RP = 64;

    typedef struct {
        logic [2:0] kind;
        logic [3:0] addr;
        logic       data;
    } ev_t;

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic       val;
    } vec_t;

    logic       Clock, Reset, ReqValid, ReqWrite, ReqData;
    logic [3:0] ReqAddr;
    logic       ReqReady, RespValid, RespData, CellWriteData, CellReadData;
    logic [3:0] CellAddr;
    logic       WriteEdge, ReadEdge, RefreshEdge;

    qsram_ctrl #(.REFRESH_PERIOD(RP), .PULSE_WIDTH(PW)) dut (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqData(ReqData), .ReqReady(ReqReady), .RespValid(RespValid),
        .RespData(RespData), .CellAddr(CellAddr), .CellWriteData(CellWriteData),
        .CellReadData(CellReadData), .WriteEdge(WriteEdge), .ReadEdge(ReadEdge),
        .RefreshEdge(RefreshEdge)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic rst_q = 1'b1;
    logic mem [16];
    ev_t  ev_q[$];
    logic resp_q[$];

    bit         in_pulse = 0;
    int         plen = 0;
    logic [3:0] paddr = 4'd0;
    logic [2:0] pkind = 3'd0;
    logic [3:0] exp_raddr = 4'd0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial for (int i = 0; i < 16; i++) mem[i] = 1'b0;
    always @(posedge Clock) if (WriteEdge) mem[CellAddr] <= CellWriteData;
    assign CellReadData = mem[CellAddr];

    always @(posedge Clock) begin
        rst_q <= Reset;
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: validates every pulse and response against the queued expectations.
    always @(negedge Clock) begin
        logic [2:0] edges;
        logic       ended_read;
        ev_t        e;
        edges = {RefreshEdge, ReadEdge, WriteEdge};
        ended_read = 1'b0;
        if (rst_q) begin
            chk("reset_edges", int'(edges), 0);
            chk("reset_resp_valid", int'(RespValid), 0);
            in_pulse  = 0;
            exp_raddr = 4'd0;
        end else begin
            chk("edge_onehot0", int'($onehot0(edges)), 1);
            if (edges != 3'd0 && !in_pulse) begin
                in_pulse = 1;
                plen     = 1;
                paddr    = CellAddr;
                pkind    = edges;
                if (edges == 3'b100) begin
                    chk("refresh_addr", int'(CellAddr), int'(exp_raddr));
                end else begin
                    chk("ev_queued", int'(ev_q.size() > 0), 1);
                    if (ev_q.size() > 0) begin
                        e = ev_q.pop_front();
                        chk("edge_kind", int'(edges), int'(e.kind));
                        chk("cell_addr", int'(CellAddr), int'(e.addr));
                        if (e.kind == 3'b001)
                            chk("cell_wdata", int'(CellWriteData), int'(e.data));
                    end
                end
            end else if (edges != 3'd0) begin
                plen++;
                chk("addr_stable", int'(CellAddr), int'(paddr));
                chk("kind_stable", int'(edges), int'(pkind));
            end else if (in_pulse) begin
                in_pulse = 0;
                chk("pulse_len", plen, PW);
                if (pkind == 3'b100) exp_raddr = exp_raddr + 4'd1;
                if (pkind == 3'b010) begin
                    ended_read = 1'b1;
                    chk("resp_valid_after_read", int'(RespValid), 1);
                    chk("resp_queued", int'(resp_q.size() > 0), 1);
                    if (RespValid && resp_q.size() > 0)
                        chk("resp_data", int'(RespData), int'(resp_q.pop_front()));
                end
            end
            if (!ended_read)
                chk("no_spurious_resp", int'(RespValid), 0);
        end
    end

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1; ReqValid = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic wait_cyc(input int k);
        int n;
        n = 0;
        while (cyc != k && n < 2000) begin
            @(negedge Clock);
            n++;
        end
        chk("wait_cyc", cyc, k);
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic wr, input logic [3:0] a, input logic d,
                         input logic push_resp, output int acc_cyc);
        int  n;
        ev_t e;
        ReqValid = 1'b1; ReqWrite = wr; ReqAddr = a; ReqData = wr ? d : 1'b0;
        n = 0;
        while (!ReqReady && n < 300) begin
            @(negedge Clock);
            n++;
        end
        chk("accept_in_time", int'(ReqReady), 1);
        acc_cyc = cyc;
        e.kind = wr ? 3'b001 : 3'b010;
        e.addr = a;
        e.data = wr ? d : 1'b0;
        ev_q.push_back(e);
        if (!wr && push_resp) resp_q.push_back(d);
        @(negedge Clock);
        ReqValid = 1'b0;
    endtask

    vec_t vecs [10] = '{
        '{1'b1, 4'd10, 1'b0}, '{1'b1, 4'd15, 1'b1}, '{1'b1, 4'd0, 1'b1},
        '{1'b0, 4'd10, 1'b0}, '{1'b0, 4'd15, 1'b1}, '{1'b0, 4'd0, 1'b1},
        '{1'b0, 4'd3, 1'b0},  '{1'b1, 4'd5, 1'b0},  '{1'b0, 4'd5, 1'b0},
        '{1'b0, 4'd15, 1'b1}
    };

    initial begin
        int acc;
        Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = 4'd0; ReqData = 1'b0;
        do_reset();
        chk("rst_ready", int'(ReqReady), 1);
        chk("rst_resp_valid", int'(RespValid), 0);
        chk("rst_resp_data", int'(RespData), 0);
        chk("rst_cell_addr", int'(CellAddr), 0);
        chk("rst_cell_wdata", int'(CellWriteData), 0);
        chk("rst_edges", int'({RefreshEdge, ReadEdge, WriteEdge}), 0);

        issue(1'b1, 4'd5, 1'b1, 1'b0, acc);
        for (int k = 1; k <= PW + 1; k++) begin
            chk("write_ready_timing", int'(ReqReady), int'(k == PW + 1));
            if (k <= PW) @(negedge Clock);
        end
        issue(1'b0, 4'd5, 1'b1, 1'b1, acc);
        for (int k = 1; k <= PW + 1; k++) begin
            chk("read_resp_timing", int'(RespValid), int'(k == PW + 1));
            if (k <= PW) @(negedge Clock);
        end
        chk("resp_data_5", int'(RespData), 1);

        foreach (vecs[i]) issue(vecs[i].wr, vecs[i].addr, vecs[i].val, 1'b1, acc);
        repeat (4) @(negedge Clock);

        issue(1'b0, 4'd15, 1'b1, 1'b0, acc);
        chk("abort_read_started", int'(ReadEdge), 1);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        chk("abort_read_edge", int'(ReadEdge), 0);
        chk("abort_ready", int'(ReqReady), 1);
        for (int k = 0; k < PW + 3; k++) begin
            chk("abort_no_resp", int'(RespValid), 0);
            @(negedge Clock);
        end

`ifdef QSRAM_REFRESH_EN
        begin
            int  seen;
            int  n;
            logic prev_r;
            do_reset();
            wait_cyc(63);
            chk("pre_wrap_ready", int'(ReqReady), 1);
            wait_cyc(64);
            chk("pending_blocks_ready", int'(ReqReady), 0);
            chk("pending_no_edge_yet", int'(RefreshEdge), 0);
            wait_cyc(65);
            chk("refresh_edge_1", int'(RefreshEdge), 1);
            chk("refresh_first_addr", int'(CellAddr), 0);
            wait_cyc(66);
            chk("refresh_edge_2", int'(RefreshEdge), 1);
            wait_cyc(67);
            chk("refresh_edge_end", int'(RefreshEdge), 0);
            chk("refresh_ready_back", int'(ReqReady), 1);
            seen = 0; n = 0; prev_r = RefreshEdge;
            while (seen < 16 && n < 1500) begin
                @(negedge Clock);
                n++;
                if (RefreshEdge && !prev_r) seen++;
                prev_r = RefreshEdge;
            end
            chk("refresh_count", seen, 16);
            chk("refresh_addr_wrapped", int'(CellAddr), 0);

            do_reset();
            wait_cyc(63);
            issue(1'b1, 4'd7, 1'b1, 1'b0, acc);
            chk("accept_on_wrap", acc, 63);
            chk("write_before_refresh", int'(WriteEdge), 1);
            wait_cyc(66);
            chk("pending_after_write", int'(ReqReady), 0);
            chk("no_refresh_yet", int'(RefreshEdge), 0);
            wait_cyc(67);
            chk("refresh_follows_write", int'(RefreshEdge), 1);
            chk("refresh_follow_addr", int'(CellAddr), 0);

            do_reset();
            wait_cyc(64);
            chk("held_off_ready", int'(ReqReady), 0);
            issue(1'b0, 4'd7, 1'b1, 1'b1, acc);
            chk("accept_after_refresh", acc, 67);
            repeat (6) @(negedge Clock);
        end
`else
        do_reset();
        for (int k = 0; k < 200; k++) begin
            chk("norefresh_edge", int'(RefreshEdge), 0);
            chk("norefresh_ready", int'(ReqReady), 1);
            @(negedge Clock);
        end
`endif

        repeat (4) @(negedge Clock);
        chk("ev_q_drained", ev_q.size(), 0);
        chk("resp_q_drained", resp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
